// File: rtl/lfsr_checker_pkg.sv
// Shared constants for the 8-bit LFSR checker: generator seed, feedback taps
// and FSM state encodings.
package lfsr_checker_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr_step.sv
// One step of the 8-bit Fibonacci LFSR (taps 7,5,4,3), shifting left.
// Purely combinational so the generator side can reuse it unchanged.
module lfsr_step
  import lfsr_checker_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {cur[6:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};

endmodule

// File: rtl/lfsr_checker.sv
// Tracks a received LFSR byte stream, declares lock after LOCK_CNT predicted
// matches and flywheels through errors. LFSR_CHK_ERRCNT_EN builds err_cnt.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power,
  input  logic        valid,
  input  logic [7:0]  data_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

  state_t     state, state_nxt;
  logic [7:0] prev, prev_nxt;
  logic [7:0] pred;
  logic [3:0] match_cnt, match_nxt;
  logic [3:0] miss_cnt, miss_nxt;
  logic       locked_nxt;
  logic       err_nxt;
  logic       accept;
  logic       hit;

  lfsr_step u_step (
    .cur (prev),
    .nxt (pred)
  );

  assign accept = valid & ~power;
  // The all-zero lock-up value can never be a legitimate successor.
  assign hit    = (data_in == pred) && (data_in != 8'h00);

  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev;
    match_nxt  = match_cnt;
    miss_nxt   = miss_cnt;
    locked_nxt = locked;
    err_nxt    = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          prev_nxt  = data_in;
          match_nxt = 4'd0;
          state_nxt = HUNT;
        end
        HUNT: begin
          prev_nxt = data_in;
          if (hit) begin
            match_nxt = match_cnt + 4'd1;
            if (match_nxt == LOCK_TGT) begin
              state_nxt  = LOCKED;
              miss_nxt   = 4'd0;
              locked_nxt = 1'b1;
            end
          end else begin
            match_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            prev_nxt = data_in;
            miss_nxt = 4'd0;
          end else begin
            // Flywheel: keep predicting from our own sequence, not the bad byte.
            prev_nxt = pred;
            miss_nxt = miss_cnt + 4'd1;
            err_nxt  = 1'b1;
            if (miss_nxt == UNLOCK_TGT) begin
              state_nxt  = HUNT;
              match_nxt  = 4'd0;
              locked_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prev      <= LFSR_SEED;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic [15:0] cnt;

  // Clear takes priority over a coincident error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'h0000;
    end else if (clr_cnt) begin
      cnt <= 16'h0000;
    end else if (err_nxt && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'h0001;
    end
  end

  assign err_cnt = cnt;
`else
  logic unused_clr;

  assign unused_clr = clr_cnt;
  assign err_cnt    = 16'h0000;
`endif

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, consecutive predicted matches required to declare lock (range 1..15).
REQ-002 SHALL have parameter UNLOCK_CNT, default 3, consecutive mismatches while locked that drop lock (range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  system reset, asynchronous, active-low.
REQ-005 SHALL have port power  input  1  system switch; checker runs only while power==0, freezes while power==1.
REQ-006 SHALL have port valid  input  1  data_in qualifier.
REQ-007 SHALL have port data_in  input  8  received pseudo-random byte from the 8-bit LFSR generator.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 SHALL have port locked  output  1  sequence lock indicator, registered.
REQ-010 SHALL have port err  output  1  one-cycle mismatch pulse, registered.
REQ-011 SHALL have port err_cnt  output  16  saturating mismatch count, registered.

Function
REQ-012 Sample accepted SHALL mean rising edge with valid==1 and power==0; no other edge changes state.
REQ-013 Prediction SHALL be next = {prev[6:0], prev[7]^prev[5]^prev[4]^prev[3]}, one generator step per accepted sample.
REQ-014 FSM SHALL have states IDLE, HUNT, LOCKED; counters match_cnt and miss_cnt 4 bits each.
REQ-015 IDLE: accepted sample -> prev<=data_in, match_cnt<=0, go HUNT.
REQ-016 HUNT: data_in==next and data_in!=8'h00 -> match_cnt+1; else match_cnt<=0; prev<=data_in always.
REQ-017 HUNT: the accepted sample making match_cnt reach LOCK_CNT -> go LOCKED, miss_cnt<=0, locked=1 from the following cycle.
REQ-018 LOCKED: match -> miss_cnt<=0, prev<=data_in; mismatch -> prev<=next (flywheel), miss_cnt+1, err=1 for exactly one cycle.
REQ-019 LOCKED: mismatch making miss_cnt reach UNLOCK_CNT -> go HUNT, match_cnt<=0, locked=0 from the following cycle.
REQ-020 err SHALL assert only in LOCKED; HUNT mismatches never pulse err.
REQ-021 err_cnt SHALL increment on each err, saturate at 16'hFFFF.
REQ-022 clr_cnt with simultaneous err SHALL yield err_cnt==0 (clear wins); err pulse still asserts.
REQ-023 power==1 SHALL hold state, prev, counters, locked; err SHALL be 0; clr_cnt still honoured.
REQ-024 8'h00 (generator lock-up value) SHALL never count as a match in any state.

Reset
REQ-025 rst==0 SHALL immediately force state IDLE, prev 8'hFF, match_cnt 0, miss_cnt 0, locked 0, err 0, err_cnt 0, including mid-lock.

Configuration
REQ-026 With LFSR_CHK_ERRCNT_EN defined, err_cnt counter and clr_cnt logic SHALL be built per REQ-021/022.
REQ-027 Without LFSR_CHK_ERRCNT_EN, err_cnt SHALL be constant 16'h0000, clr_cnt ignored; all other behaviour unchanged.

Structure
REQ-028 Shared package SHALL hold LFSR seed 8'hFF, tap constants (7,5,4,3), FSM state encodings.
REQ-029 Combinational sub-module lfsr_step (8-bit in -> 8-bit next) SHALL compute the prediction, reusable by the generator.

Verification
REQ-030 Reset, power=0, feed FF,FE,FC,F8,F0 valid consecutive -> locked=1 cycle after F0 accepted, err never 1.
REQ-031 Locked after F0, feed 00 then C2 -> err pulse one cycle after 00, err_cnt=1, C2 accepted as match, locked stays 1.
REQ-032 Locked, feed three consecutive wrong bytes (55,55,55) -> three err pulses, err_cnt=3, locked=0 after third.
REQ-033 From reset, feed 00 ten times -> locked stays 0, err stays 0, err_cnt 0.
REQ-034 Locked, power=1 for 5 cycles with valid=1 garbage, then power=0 and resume sequence -> no err, locked stays 1.
REQ-035 err_cnt preset near 16'hFFFF via repeated errors -> saturates at FFFF; clr_cnt coincident with err -> err_cnt=0; rst=0 mid-lock -> all outputs 0 asynchronously.
